// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the segmented, pipelined add/subtract unit.
package addsub_pkg;

    localparam logic MODE_ADD   = 1'b0;
    localparam logic MODE_SUB   = 1'b1;
    localparam int   MAX_STAGES = 8;

    // Bits handled by each pipeline segment; guards against a zero stage count.
    function automatic int seg_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

endpackage

// File: rtl/addsub_segment.sv
// One carry-chained slice of the adder: SEG-bit sum plus carry in, carry out.
module addsub_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit add/subtract split into STAGES carry-chained segments, one per pipeline rank,
// with a single global stall derived from the output handshake.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_sub,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int PIPE = (STAGES > 1) ? STAGES - 1 : 1;

    if ((STAGES < 1) || (STAGES > MAX_STAGES) ||
        ((WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0)) begin : g_bad_params
        $error("pipelined_addsub: STAGES must be 1..8 and divide WIDTH");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    // Internal ranks: operands skew forward while finished low segments accumulate in sum.
    logic [WIDTH-1:0] a_pipe_reg     [PIPE];
    logic [WIDTH-1:0] b_pipe_reg     [PIPE];
    logic [WIDTH-1:0] sum_pipe_reg   [PIPE];
    logic             carry_pipe_reg [PIPE];
    logic             valid_pipe_reg [PIPE];

    logic [SEG-1:0]   seg_sum  [STAGES];
    logic             seg_cout [STAGES];

    logic [WIDTH-1:0] final_sum;
    logic             final_valid;
    logic             final_a_msb;
    logic             final_b_msb;
    logic             final_cout;

    logic [WIDTH-1:0] out_reg;
    logic             out_valid_reg;
    logic             carry_out_reg;
    logic             overflow_reg;
    logic             zero_reg;

    assign advance  = out_ready || !out_valid_reg;
    assign in_ready = advance;
    assign b_eff    = (is_sub == MODE_ADD) ? input2 : ~input2;
    assign cin0     = (is_sub == MODE_ADD) ? carry_in : 1'b1;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_seg
        if (gi == 0) begin : g_first
            addsub_segment #(.SEG(SEG)) u_seg (
                .a    (input1[SEG-1:0]),
                .b    (b_eff[SEG-1:0]),
                .cin  (cin0),
                .sum  (seg_sum[0]),
                .cout (seg_cout[0])
            );
        end else begin : g_next
            addsub_segment #(.SEG(SEG)) u_seg (
                .a    (a_pipe_reg[gi-1][gi*SEG +: SEG]),
                .b    (b_pipe_reg[gi-1][gi*SEG +: SEG]),
                .cin  (carry_pipe_reg[gi-1]),
                .sum  (seg_sum[gi]),
                .cout (seg_cout[gi])
            );
        end
    end

    if (STAGES == 1) begin : g_final_single
        assign final_sum   = seg_sum[0];
        assign final_valid = in_valid;
        assign final_a_msb = input1[WIDTH-1];
        assign final_b_msb = b_eff[WIDTH-1];
    end else begin : g_final_multi
        assign final_sum   = {seg_sum[STAGES-1], sum_pipe_reg[STAGES-2][WIDTH-SEG-1:0]};
        assign final_valid = valid_pipe_reg[STAGES-2];
        assign final_a_msb = a_pipe_reg[STAGES-2][WIDTH-1];
        assign final_b_msb = b_pipe_reg[STAGES-2][WIDTH-1];
    end

    assign final_cout = seg_cout[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < PIPE; k++) begin
                valid_pipe_reg[k] <= 1'b0;
            end
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b1;
        end else if (advance) begin
            if (STAGES > 1) begin
                valid_pipe_reg[0] <= in_valid;
                a_pipe_reg[0]     <= input1;
                b_pipe_reg[0]     <= b_eff;
                sum_pipe_reg[0]   <= '0;
                sum_pipe_reg[0][SEG-1:0] <= seg_sum[0];
                carry_pipe_reg[0] <= seg_cout[0];
            end
            for (int k = 1; k < STAGES - 1; k++) begin
                valid_pipe_reg[k] <= valid_pipe_reg[k-1];
                a_pipe_reg[k]     <= a_pipe_reg[k-1];
                b_pipe_reg[k]     <= b_pipe_reg[k-1];
                sum_pipe_reg[k]   <= sum_pipe_reg[k-1];
                sum_pipe_reg[k][k*SEG +: SEG] <= seg_sum[k];
                carry_pipe_reg[k] <= seg_cout[k];
            end
            out_valid_reg <= final_valid;
            // Bubbles leave the last result and its flags untouched.
            if (final_valid) begin
                out_reg       <= final_sum;
                carry_out_reg <= final_cout;
                zero_reg      <= (final_sum == '0);
                overflow_reg  <= (final_a_msb == final_b_msb) &&
                                 (final_sum[WIDTH-1] != final_a_msb);
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomized self-checking bench: scoreboard fed by an arithmetic reference model,
// plus directed latency checks on STAGES=1 and STAGES=8 instances.
module tb_pipelined_addsub;
    import addsub_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid;
    logic         is_sub;
    logic         carry_in;
    logic         out_ready;
    logic [W-1:0] input1;
    logic [W-1:0] input2;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    logic         x_valid;
    logic         x_is_sub;
    logic         x_cin;
    logic         x_out_ready;
    logic [W-1:0] x_a;
    logic [W-1:0] x_b;
    logic         s1_in_ready, s1_valid, s1_carry, s1_ovf, s1_zero;
    logic [W-1:0] s1_out;
    logic         s8_in_ready, s8_valid, s8_carry, s8_ovf, s8_zero;
    logic [W-1:0] s8_out;

    pipelined_addsub #(.WIDTH(W), .STAGES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .is_sub(is_sub), .carry_in(carry_in), .input1(input1), .input2(input2),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    pipelined_addsub #(.WIDTH(W), .STAGES(1)) dut_s1 (
        .clk(clk), .reset(reset), .in_valid(x_valid), .in_ready(s1_in_ready),
        .is_sub(x_is_sub), .carry_in(x_cin), .input1(x_a), .input2(x_b),
        .out_valid(s1_valid), .out_ready(x_out_ready), .out(s1_out),
        .carry_out(s1_carry), .overflow(s1_ovf), .zero(s1_zero)
    );

    pipelined_addsub #(.WIDTH(W), .STAGES(8)) dut_s8 (
        .clk(clk), .reset(reset), .in_valid(x_valid), .in_ready(s8_in_ready),
        .is_sub(x_is_sub), .carry_in(x_cin), .input1(x_a), .input2(x_b),
        .out_valid(s8_valid), .out_ready(x_out_ready), .out(s8_out),
        .carry_out(s8_carry), .overflow(s8_ovf), .zero(s8_zero)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   out_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: true-value arithmetic, then reduce modulo 2^W and test signed range.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        exp_t e;
        longint sa, sb, s;
        longint unsigned full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub == MODE_SUB) begin
            e.res = a - b;
            e.c   = (a >= b);
            s     = sa - sb;
        end else begin
            full  = 64'(a) + 64'(b) + 64'(cin);
            e.res = full[W-1:0];
            e.c   = full[W];
            s     = sa + sb + longint'(cin);
        end
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.z = (e.res == '0);
        return e;
    endfunction

    // Scoreboard: decides transfers just before the edge on which they happen.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_seen++;
                $display("out #%0d: 0x%08h c=%b v=%b z=%b", out_seen, out, carry_out, overflow, zero);
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out", 64'(out), 64'(e.res));
                    check("carry_out", 64'(carry_out), 64'(e.c));
                    check("overflow", 64'(overflow), 64'(e.v));
                    check("zero", 64'(zero), 64'(e.z));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(input1, input2, is_sub, carry_in));
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
        bit acc;
        int n;
        n = 0;
        input1 = a; input2 = b; is_sub = sub; carry_in = cin; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 64'(acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    // One op into the STAGES=1 and STAGES=8 instances; latency and value of each.
    task automatic x_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
        exp_t e;
        int lat1, lat8;
        e = model(a, b, sub, cin);
        lat1 = 0; lat8 = 0;
        x_a = a; x_b = b; x_is_sub = sub; x_cin = cin; x_valid = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) x_valid = 1'b0;
            if (s1_valid && lat1 == 0) begin
                lat1 = n;
                check("s1_out", 64'(s1_out), 64'(e.res));
                check("s1_carry", 64'(s1_carry), 64'(e.c));
                check("s1_ovf", 64'(s1_ovf), 64'(e.v));
                check("s1_zero", 64'(s1_zero), 64'(e.z));
            end
            if (s8_valid && lat8 == 0) begin
                lat8 = n;
                check("s8_out", 64'(s8_out), 64'(e.res));
                check("s8_carry", 64'(s8_carry), 64'(e.c));
                check("s8_ovf", 64'(s8_ovf), 64'(e.v));
                check("s8_zero", 64'(s8_zero), 64'(e.z));
            end
        end
        $display("x_op a=0x%08h b=0x%08h sub=%b: lat1=%0d lat8=%0d", a, b, sub, lat1, lat8);
        check("s1_latency", 64'(lat1), 64'(1));
        check("s8_latency", 64'(lat8), 64'(8));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
        $fatal(1, "time limit");
    end

    initial begin
        int lat, seen_before;
        logic [W-1:0] held;

        reset = 1'b1; in_valid = 1'b0; is_sub = 1'b0; carry_in = 1'b0; out_ready = 1'b1;
        input1 = '0; input2 = '0;
        x_valid = 1'b0; x_is_sub = 1'b0; x_cin = 1'b0; x_out_ready = 1'b1; x_a = '0; x_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out", 64'(out), 64'(0));
        check("rst_carry", 64'(carry_out), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_zero", 64'(zero), 64'(1));
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // 5 + 3 with latency measured from the accepting edge
        reset = 1'b0;
        input1 = 32'h5; input2 = 32'h3; is_sub = MODE_ADD; carry_in = 1'b0; in_valid = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) in_valid = 1'b0;
            if (out_valid && lat == 0) begin
                lat = n;
                check("t1_out", 64'(out), 64'h8);
                check("t1_zero", 64'(zero), 64'(0));
            end
        end
        check("t1_latency", 64'(lat), 64'(4));
        drain();

        x_op(32'h5, 32'h3, MODE_ADD, 1'b0);
        x_op(32'h3, 32'h5, MODE_SUB, 1'b0);
        x_op($urandom, $urandom, MODE_ADD, 1'b1);

        // Carry ripple, overflow and subtract corner cases
        send(32'hFFFF_FFFF, 32'h0000_0001, MODE_ADD, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, MODE_ADD, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, MODE_ADD, 1'b1);
        send(32'h0000_0003, 32'h0000_0005, MODE_SUB, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, MODE_SUB, 1'b1);
        send(32'h0000_0000, 32'h8000_0000, MODE_SUB, 1'b0);
        drain();

        // Back-to-back random ops
        repeat (8) send_rand();
        drain();

        // Fill the pipe with the consumer stalled
        out_ready = 1'b0;
        repeat (4) send_rand();
        check("fill_out_valid", 64'(out_valid), 64'(1));
        held = out;
        input1 = $urandom; input2 = $urandom; is_sub = MODE_ADD; carry_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_out", 64'(out), 64'(held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(input1, input2, is_sub, carry_in);
        repeat (3) send_rand();
        drain();

        // Random gaps against random backpressure
        fork
            begin
                repeat (30) begin
                    send_rand();
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                repeat (150) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three ops in flight and a fourth presented alongside reset
        repeat (3) send_rand();
        reset = 1'b1;
        input1 = $urandom; input2 = $urandom; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_zero", 64'(zero), 64'(1));
        reset = 1'b0;
        in_valid = 1'b0;
        seen_before = out_seen;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        check("midrst_no_stale", 64'(out_seen - seen_before), 64'(0));

        send(32'h1234_5678, 32'h1111_1111, MODE_SUB, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
